// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/four_bit_adder.sv
// Plain 4-bit ripple adder with carry in/out; the single datapath shared by the sequencer.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign sum   = total[3:0];
  assign cout  = total[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds or subtracts two WIDTH-bit operands one nibble per cycle through a single four_bit_adder,
// LS nibble first, with valid/ready handshakes on request and result. WIDTH: multiple of 4, >= 8.
module nibble_serial_adder_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = $clog2(NIB);
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;

  four_bit_adder u_adder (
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          // Subtraction is A + ~B + 1, so the inverted B is what feeds the overflow check.
          a_sh_d     = op_a;
          b_sh_d     = sub ? ~op_b : op_b;
          carry_d    = sub ? 1'b1 : cin;
          a_msb_d    = op_a[WIDTH-1];
          b_msb_d    = sub ? ~op_b[WIDTH-1] : op_b[WIDTH-1];
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> NIBBLE_W;
        b_sh_d   = b_sh_q >> NIBBLE_W;
        res_sh_d = {add_sum, res_sh_q[WIDTH-1:NIBBLE_W]};
        carry_d  = add_cout;
        cnt_d    = CW'(cnt_q + 1'b1);
        if (cnt_q == LAST_NIB) begin
          // The nibble just summed holds the result MSB.
          ovf_d       = (a_msb_q == b_msb_q) && (add_sum[NIBBLE_W-1] != a_msb_q);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_sh_q;
  assign cout      = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed plus random bench for nibble_serial_adder_ctrl (WIDTH=16) with an expected-result queue.
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic s);
    logic [W-1:0] be;
    logic [W:0]   tot;
    exp_t         e;
    be    = s ? ~b : b;
    tot   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    e.r   = tot[W-1:0];
    e.c   = tot[W];
    e.o   = (a[W-1] == be[W-1]) && (tot[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic s, input exp_t e);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    op_a = a; op_b = b; cin = ci; sub = s; in_valid = 1'b1;
    sb_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input bit check_lat);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    if (check_lat) chk({tag, "_latency"}, cyc, 32'd4);
    e = sb_q.pop_front();
    chk({tag, "_result"}, {16'd0, result}, {16'd0, e.r});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, e.c});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.o});
    $display("op %s: result=%h cout=%0b ovf=%0b lat=%0d", tag, result, cout, ovf, cyc);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic s, input exp_t e);
    send(a, b, ci, s, e);
    collect(tag, 1'b1);
  endtask

  initial begin : stim
    logic [W-1:0] held_r;
    logic         held_c;
    logic         held_o;
    logic [W-1:0] ra, rb;
    logic         rc, rs;

    repeat (2) tick();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", {16'd0, result}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op("add_zero",   16'h0000, 16'h0000, 1'b0, 1'b0, '{r: 16'h0000, c: 1'b0, o: 1'b0});
    run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b1, 1'b0, '{r: 16'h0001, c: 1'b1, o: 1'b0});
    run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, '{r: 16'h8000, c: 1'b0, o: 1'b1});
    run_op("sub_borrow", 16'h0003, 16'h0005, 1'b1, 1'b1, '{r: 16'hFFFE, c: 1'b0, o: 1'b0});
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, '{r: 16'h7FFF, c: 1'b1, o: 1'b1});

    // Backpressure: hold result while a new request waits.
    send(16'h00F0, 16'h0F0F, 1'b0, 1'b0, '{r: 16'h0FFF, c: 1'b0, o: 1'b0});
    repeat (4) tick();
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    held_r = result; held_c = cout; held_o = ovf;
    chk("bp_first_result", {16'd0, held_r}, 32'h0FFF);
    op_a = 16'h4000; op_b = 16'h4000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_result", {16'd0, result}, {16'd0, held_r});
      chk("bp_hold_flags", {30'd0, cout, ovf}, {30'd0, held_c, held_o});
    end
    void'(sb_q.pop_front());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    sb_q.push_back('{r: 16'h8000, c: 1'b0, o: 1'b1});
    tick();
    in_valid = 1'b0;
    chk("bp_pending_taken", {31'd0, in_ready}, 32'd0);
    collect("bp_pending", 1'b0);

    // Reset mid-RUN discards the operation.
    send(16'h1234, 16'h1111, 1'b0, 1'b0, '{r: 16'h2345, c: 1'b0, o: 1'b0});
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_no_pulse", {31'd0, out_valid}, 32'd0);
    run_op("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, '{r: 16'h2345, c: 1'b0, o: 1'b0});

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      run_op("random", ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that adds or subtracts two WIDTH-bit operands using a single `four_bit_adder` datapath, one nibble per clock, least-significant nibble first. It owns the carry chain between nibbles, latches operands and accumulates the result, and presents the result through valid/ready handshakes on both sides. It lets wide arithmetic share one 4-bit adder instead of replicating adders across the word.

## Interface
- `WIDTH`, default 16: operand and result width in bits. Must be a multiple of 4 and at least 8.
- `NIB`, derived as WIDTH/4: nibble count. Localparam, not overridable.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operation request.
- `in_ready`  out  1: block can accept a request; high only in IDLE.
- `op_a`  in  WIDTH: operand A.
- `op_b`  in  WIDTH: operand B.
- `cin`  in  1: carry-in for add mode; ignored in subtract mode.
- `sub`  in  1: 0 computes A+B+cin; 1 computes A−B, i.e. A+~B+1.
- `out_valid`  out  1: result, cout and ovf are valid.
- `out_ready`  in  1: consumer accepts the result.
- `result`  out  WIDTH: sum or difference, modulo 2^WIDTH.
- `cout`  out  1: carry out of the MSB. In subtract mode, 1 means no borrow.
- `ovf`  out  1: two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`:
  - latch A into `a_sh`; latch B, or ~B when `sub`=1, into `b_sh`;
  - set the carry register to `cin`, or to 1 when `sub`=1;
  - save the MSBs of A and effective B for the overflow check;
  - clear the nibble counter; go to RUN.
- RUN: each cycle the adder receives `a_sh[3:0]`, `b_sh[3:0]` and the carry register.
  - The adder sum shifts into the top of `res_sh`; `res_sh`, `a_sh` and `b_sh` shift right by 4.
  - The carry register takes the adder cout; the counter increments.
  - When counter = NIB−1, go to DONE.
- DONE: `out_valid`=1. `result`=`res_sh`; `cout`=carry register; `ovf`=(A_msb == Beff_msb) && (result[WIDTH−1] != A_msb).
  - On `out_valid && out_ready`, go to IDLE.
- While not in IDLE, `in_valid` is ignored (`in_ready`=0) and no input is sampled.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `cout`=0, `ovf`=0. The counter and shift registers are cleared.

## Timing
- Accept at edge T0; RUN covers edges T1..TNIB; `out_valid` rises after edge TNIB.
  - Latency from accept to `out_valid` is NIB cycles: 4 for WIDTH=16.
- Result handshake at edge Tk: `in_ready` is high in the next cycle.
  - Best-case throughput is one operation per NIB+2 cycles.
- `out_ready` low in DONE: `result`, `cout` and `ovf` hold stable indefinitely.
- `out_ready` high on the first DONE cycle: one-cycle DONE, no extra stall.
- `rst` asserted in any state, including mid-RUN: the block returns immediately to the reset values. The partial result is discarded and no `out_valid` pulse is produced.
- Counter wrap: the counter is compared against NIB−1 and never wraps in normal operation.

## Structure
- Package `nibble_add_pkg`: state enum (IDLE, RUN, DONE) and `NIBBLE_W`=4.
- One sub-module: the existing `four_bit_adder` (ports a, b, cin, sum, cout), instantiated once.
- The FSM, counter and shift registers stay in this module.

## Test plan
All scenarios use WIDTH=16.
1. Add 0x0000 + 0x0000, `cin`=0 → `result`=0x0000, `cout`=0, `ovf`=0. `out_valid` rises exactly 4 cycles after the accept edge.
2. Add 0xFFFF + 0x0001, `cin`=1 → `result`=0x0001, `cout`=1, `ovf`=0. This exercises the carry ripple through all nibbles.
3. Add 0x7FFF + 0x0001, `cin`=0 → `result`=0x8000, `cout`=0, `ovf`=1.
4. Subtract 0x0003 − 0x0005 → `result`=0xFFFE, `cout`=0 (borrow), `ovf`=0. Then subtract 0x8000 − 0x0001 → `result`=0x7FFF, `cout`=1, `ovf`=1.
5. Hold `out_ready`=0 for 5 cycles in DONE while driving a new `in_valid` → outputs stay stable, `in_ready`=0, and the new request is not taken. Raise `out_ready` → `in_ready`=1 on the next cycle, and the pending request is then accepted.
6. Assert `rst` after 2 RUN cycles of 0x1234 + 0x1111 → `out_valid`=0 and `in_ready`=1 immediately. A following 0x1234 + 0x1111 returns 0x2345, `cout`=0.
